bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one single-port 32-bit block RAM between two req/gnt requesters
//  (m0: the AHB-lite BRAM slave path, m1: a DMA/peripheral engine).
//  Round-robin arbitration, optional bounded burst lock, 1-cycle read return.
//  Sits between the requesters and the BRAM macro port (addr/wdata/write/rdata).
// PARAMETERS
//  ADDR_WIDTH  14  BRAM word-address width
//  MAX_BURST   8   max consecutive locked grants to one port (>=1)
// PORTS
//  HCLK        in   1   clock
//  HRESETn     in   1   asynchronous, active-low reset
//  m0_req      in   1   m0 access request (valid with addr/wdata/we)
//  m0_lock     in   1   m0 wants to keep grant next cycle
//  m0_addr     in   AW  m0 word address
//  m0_wdata    in   32  m0 write data
//  m0_we       in   4   m0 byte write enables; 0 = read
//  m0_gnt      out  1   m0 access issued to BRAM this cycle
//  m0_rvalid   out  1   m0 read data valid (cycle after granted read)
//  m1_*        same set as m0_* for requester 1
//  rdata       out  32  read data, shared by both ports (= bram_rdata)
//  bram_addr   out  AW  BRAM address
//  bram_wdata  out  32  BRAM write data
//  bram_write  out  4   BRAM byte write strobes
//  bram_rdata  in   32  BRAM read data (sync, 1-cycle latency)
// BEHAVIOUR
//  - Reset (async): gnt/rvalid 0, bram_write 0, state IDLE, last_q=1
//    (m0 wins first tie), burst_cnt 0, addr_q 0.
//  - State: IDLE, OWN0, OWN1 (owner holding a lock). gnt is combinational
//    from req + state + last_q; at most one gnt per cycle (one-hot-or-zero).
//  - IDLE arbitration: single req -> grant it; both -> grant port != last_q.
//    On any grant last_q <= grantee.
//  - Lock: grantee with req&lock -> next state OWNx, burst_cnt++.
//    OWNx: port x granted if m_x_req, ignoring other port. Leave to IDLE when
//    req or lock drops, or burst_cnt reaches MAX_BURST-1 (forced release);
//    on forced release other port has priority next cycle if requesting.
//    burst_cnt clears on every return to IDLE. Lock with req=0 is ignored.
//  - Datapath: granted port drives bram_addr/bram_wdata, bram_write=m_we.
//    No grant: bram_write=0, bram_addr=addr_q (last granted addr, held),
//    bram_wdata=0. addr_q updates on every grant.
//  - Read: granted with we==0 -> mx_rvalid=1 next cycle, rdata=bram_rdata;
//    rvalid registered, one cycle wide, never on both ports.
//  - Back-to-back accesses no bubbles: a grant is possible every cycle,
//    including read following write to same addr (data is BRAM write-first).
//  - No reordering or buffering; ungranted requester must hold req/addr/data.
//  - Reset mid-burst: state IDLE immediately, pending rvalid dropped.
// STRUCTURE
//  - Shared package bram_arb_pkg: state enum {IDLE,OWN0,OWN1}, port index
//    constants P0=0/P1=1.
//  - One sub-module natural: bram_rr_arb2 (2-way round-robin pick from
//    req[1:0] + last, combinational); burst FSM, counter, muxes in top.
// TESTING
//  - Reset: deassert HRESETn mid-run -> gnt=0, rvalid=0, bram_write=0 at once.
//  - Both req reads from reset, m0 addr 0x010, m1 addr 0x020 held -> grants
//    alternate m0,m1,m0..., each rvalid one cycle later with matching rdata.
//  - m0 write 0xDEADBEEF we=4'hF @0x005, then read @0x005 next cycle ->
//    two consecutive grants, m0_rvalid with rdata 0xDEADBEEF.
//  - m1 req+lock held continuously, m0 req held, MAX_BURST=8 -> m1 gets
//    exactly 8 grants in a row, then m0 granted next cycle.
//  - Byte write we=4'b0010 data 0x0000AB00 onto 0x11223344 -> readback
//    0x1122AB44; bram_write=4'b0010 in the grant cycle only.
//  - Idle after grant @0x3FFF -> bram_addr stays 0x3FFF, bram_write 0,
//    no rvalid; m0_lock=1 with m0_req=0 -> state stays IDLE.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: burst-ownership states and
// port index constants.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, and a tie goes to the
// port that was not granted last.
module bram_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    import bram_arb_pkg::*;

    // Combinational pick, one-hot-or-zero.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == P0) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port 32-bit BRAM between two req/gnt requesters with
// round-robin arbitration, bounded burst lock and 1-cycle read return.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_we,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_we,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    output logic [3:0]            bram_write,
    input  logic [31:0]           bram_rdata
);
    import bram_arb_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    // With MAX_BURST==1 every grant is already a forced release.
    localparam bit BURST_EN = (MAX_BURST > 1);

    arb_state_e            state_q, state_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  m0_rvalid_q, m1_rvalid_q;
    logic [1:0]            rr_gnt;

    bram_rr_arb2 u_rr (
        .req_i  ({m1_req, m0_req}),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    // Grant selection: round-robin when idle, owner-only while locked.
    // Reset gates the grants so nothing reaches the BRAM while held.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                m0_gnt = rr_gnt[0];
                m1_gnt = rr_gnt[1];
            end
            OWN0:    m0_gnt = m0_req;
            OWN1:    m1_gnt = m1_req;
            default: ;
        endcase
        m0_gnt = m0_gnt & HRESETn;
        m1_gnt = m1_gnt & HRESETn;
    end

    // Burst FSM next state, lock counter and round-robin history.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (m0_gnt) last_d = P0;
        if (m1_gnt) last_d = P1;
        case (state_q)
            IDLE: begin
                if (BURST_EN && m0_gnt && m0_lock) begin
                    state_d = OWN0;
                    cnt_d   = cnt_q + 1'b1;
                end else if (BURST_EN && m1_gnt && m1_lock) begin
                    state_d = OWN1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            OWN0: begin
                if (!(m0_req && m0_lock) || (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            OWN1: begin
                if (!(m1_req && m1_lock) || (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // BRAM port mux: granted port drives the macro, otherwise hold address.
    always_comb begin
        bram_addr  = addr_q;
        bram_wdata = 32'd0;
        bram_write = 4'd0;
        if (m0_gnt) begin
            bram_addr  = m0_addr;
            bram_wdata = m0_wdata;
            bram_write = m0_we;
        end else if (m1_gnt) begin
            bram_addr  = m1_addr;
            bram_wdata = m1_wdata;
            bram_write = m1_we;
        end
    end

    // Control and held-address registers; read-valid follows a granted read.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            last_q      <= P1;
            cnt_q       <= '0;
            addr_q      <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= bram_addr;
            m0_rvalid_q <= m0_gnt && (m0_we == 4'd0);
            m1_rvalid_q <= m1_gnt && (m1_we == 4'd0);
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign rdata     = bram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed grant checks plus a
// read-data scoreboard fed from a reference memory image.
module tb_bram_port_arbiter;

    localparam int AW = 14;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          m0_req, m0_lock, m1_req, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_we, m1_we;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   rdata, bram_wdata, bram_rdata;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_write;

    always #5 HCLK = ~HCLK;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_write(bram_write), .bram_rdata(bram_rdata)
    );

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return {18'h2A5C3, a} ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural BRAM: synchronous, write-first, 1-cycle read latency.
    logic [31:0] mem [int];
    always @(posedge HCLK) begin
        logic [31:0] cur;
        cur = mem.exists(int'(bram_addr)) ? mem[int'(bram_addr)] : init_word(bram_addr);
        if (bram_write != 4'd0) begin
            cur = merge(cur, bram_wdata, bram_write);
            mem[int'(bram_addr)] = cur;
        end
        bram_rdata <= cur;
    end

    typedef struct { logic port; logic [31:0] data; } exp_t;
    exp_t        sb [$];
    logic [31:0] ref_mem [int];
    int          total = 0;
    int          bad   = 0;
    logic        g0, g1, rv0, rv1;
    logic [3:0]  bw;
    logic [AW-1:0] ba;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    // One clock cycle: sample at the falling edge, score read returns, record
    // accesses into the reference image, then move to just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge HCLK);
        g0 = m0_gnt; g1 = m1_gnt; rv0 = m0_rvalid; rv1 = m1_rvalid;
        bw = bram_write; ba = bram_addr;
        chk("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
        if (rv0 || rv1) begin
            chk("rv_both", {31'd0, rv0 & rv1}, 32'd0);
            if (sb.size() == 0) begin
                chk("rv_spurious", {31'd0, rv1}, {31'd0, ~rv1});
            end else begin
                e = sb.pop_front();
                chk("rv_port", {31'd0, rv1}, {31'd0, e.port});
                chk("rdata", rdata, e.data);
            end
        end
        if (m0_gnt) begin
            if (m0_we == 4'd0) sb.push_back('{port: 1'b0, data: ref_rd(m0_addr)});
            else ref_mem[int'(m0_addr)] = merge(ref_rd(m0_addr), m0_wdata, m0_we);
        end
        if (m1_gnt) begin
            if (m1_we == 4'd0) sb.push_back('{port: 1'b1, data: ref_rd(m1_addr)});
            else ref_mem[int'(m1_addr)] = merge(ref_rd(m1_addr), m1_wdata, m1_we);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_wdata = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_wdata = 0;
    endtask

    initial begin
        idle_all();
        m0_addr = '0; m1_addr = '0;
        HRESETn = 1'b0;
        m0_req  = 1'b1;
        #12;
        chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("rst_rv0", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_bw", {28'd0, bram_write}, 32'd0);
        chk("rst_ba", {18'd0, bram_addr}, 32'd0);
        m0_req = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Both ports read continuously: grants alternate starting with m0.
        m0_req = 1; m0_addr = 14'h010;
        m1_req = 1; m1_addr = 14'h020;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("alt_g0", {31'd0, g0}, {31'd0, (i % 2) == 0});
            chk("alt_g1", {31'd0, g1}, {31'd0, (i % 2) == 1});
        end
        idle_all();
        tick();

        // Write then read of the same word on consecutive cycles.
        m0_req = 1; m0_addr = 14'h005; m0_wdata = 32'hDEADBEEF; m0_we = 4'hF;
        tick();
        chk("wr_gnt", {31'd0, g0}, 32'd1);
        chk("wr_bw", {28'd0, bw}, 32'hF);
        m0_we = 4'h0; m0_wdata = 32'd0;
        tick();
        chk("rd_gnt", {31'd0, g0}, 32'd1);
        idle_all();
        tick();
        chk("raw_rv0", {31'd0, rv0}, 32'd1);
        chk("raw_data", rdata, 32'hDEADBEEF);

        // m1 holds lock while m0 keeps requesting: 8 locked grants, then m0.
        m0_req = 1; m0_addr = 14'h010;
        m1_req = 1; m1_lock = 1; m1_addr = 14'h020;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("burst_g1", {31'd0, g1}, 32'd1);
            chk("burst_g0", {31'd0, g0}, 32'd0);
        end
        tick();
        chk("release_g0", {31'd0, g0}, 32'd1);

        // Reset while m1 owns a fresh burst with a read return pending.
        tick();
        chk("relock_g1", {31'd0, g1}, 32'd1);
        #1 HRESETn = 1'b0;
        #1;
        chk("mid_rst_g0", {31'd0, m0_gnt}, 32'd0);
        chk("mid_rst_g1", {31'd0, m1_gnt}, 32'd0);
        chk("mid_rst_rv1", {31'd0, m1_rvalid}, 32'd0);
        chk("mid_rst_bw", {28'd0, bram_write}, 32'd0);
        sb.delete();
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        tick();
        chk("post_rst_g0", {31'd0, g0}, 32'd1);
        chk("post_rst_g1", {31'd0, g1}, 32'd0);
        idle_all();
        tick();

        // Byte-lane write merges into an existing word.
        m1_req = 1; m1_addr = 14'h030; m1_wdata = 32'h11223344; m1_we = 4'hF;
        tick();
        m1_wdata = 32'h0000AB00; m1_we = 4'b0010;
        tick();
        chk("byte_bw", {28'd0, bw}, 32'h2);
        m1_wdata = 32'd0; m1_we = 4'd0;
        tick();
        chk("byte_rd_bw", {28'd0, bw}, 32'd0);
        chk("byte_rd_g1", {31'd0, g1}, 32'd1);
        idle_all();
        tick();
        chk("byte_rv1", {31'd0, rv1}, 32'd1);
        chk("byte_data", rdata, 32'h1122AB44);

        // Idle after a grant holds the address; lock without req is ignored.
        m0_req = 1; m0_addr = 14'h3FFF;
        tick();
        chk("top_g0", {31'd0, g0}, 32'd1);
        m0_req = 0; m0_lock = 1;
        tick();
        chk("hold_ba", {18'd0, ba}, 32'h3FFF);
        chk("hold_bw", {28'd0, bw}, 32'd0);
        chk("hold_g0", {31'd0, g0}, 32'd0);
        m1_req = 1; m1_addr = 14'h040;
        tick();
        chk("nolock_rv0", {31'd0, rv0}, 32'd0);
        chk("nolock_g1", {31'd0, g1}, 32'd1);
        idle_all();
        tick();
        tick();
        chk("end_rv0", {31'd0, rv0}, 32'd0);
        chk("end_rv1", {31'd0, rv1}, 32'd0);
        chk("end_ba", {18'd0, ba}, 32'h040);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
